// File: rtl/stream_pkg.sv
// Shared constants for the uplink stream merger: packet type codes, port indices, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_pkg;

    localparam logic [7:0] PKT_TYPE_PLAYER = 8'h01;
    localparam logic [7:0] PKT_TYPE_BULLET = 8'h02;
    localparam logic [7:0] PKT_TYPE_ENEMY  = 8'h03;
    localparam logic [7:0] PKT_TYPE_RSVD   = 8'h04;

    localparam logic [1:0] PORT_PLAYER = 2'd0;
    localparam logic [1:0] PORT_BULLET = 2'd1;
    localparam logic [1:0] PORT_RSVD   = 2'd2;
    localparam logic [1:0] PORT_ENEMY  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Type code stamped into the low data byte for a given producer port.
    function automatic logic [7:0] pkt_type(input logic [1:0] port);
        logic [7:0] code;
        case (port)
            PORT_PLAYER: code = PKT_TYPE_PLAYER;
            PORT_BULLET: code = PKT_TYPE_BULLET;
            PORT_RSVD:   code = PKT_TYPE_RSVD;
            default:     code = PKT_TYPE_ENEMY;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first requester scanning upward from (last+1) with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_priority_select (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_grant,
    output logic       o_found
);

    // Scan the four positions after the last winner; the first requester wins.
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        o_grant = '0;
        o_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = i_last + 2'(i);
            if (!o_found && i_req[idx]) begin
                o_grant = idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-aware 4:1 stream merger: round-robin at packet boundaries, registered output slice.
// Latency: one cycle from input beat acceptance to output valid; one idle cycle between packets.
// Backpressure: granted port ready = output empty or downstream ready; other ports held off.
module stream_arbiter #(
    parameter int DATA_W     = 64,
    parameter int STAMP_TYPE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_s_axis_port0_tdata,
    input  logic              i_s_axis_port0_tvalid,
    input  logic              i_s_axis_port0_tlast,
    output logic              o_s_axis_port0_tready,
    input  logic [DATA_W-1:0] i_s_axis_port1_tdata,
    input  logic              i_s_axis_port1_tvalid,
    input  logic              i_s_axis_port1_tlast,
    output logic              o_s_axis_port1_tready,
    input  logic [DATA_W-1:0] i_s_axis_port2_tdata,
    input  logic              i_s_axis_port2_tvalid,
    input  logic              i_s_axis_port2_tlast,
    output logic              o_s_axis_port2_tready,
    input  logic [DATA_W-1:0] i_s_axis_port3_tdata,
    input  logic              i_s_axis_port3_tvalid,
    input  logic              i_s_axis_port3_tlast,
    output logic              o_s_axis_port3_tready,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    output logic              o_m_axis_tlast,
    input  logic              i_m_axis_tready,
    output logic [1:0]        o_grant,
    output logic              o_busy
);
    import stream_pkg::*;

    arb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic [DATA_W-1:0] m_dat_q, m_dat_d;
    logic              m_vld_q, m_vld_d;
    logic              m_last_q, m_last_d;

    logic [DATA_W-1:0] in_dat [4];
    logic [3:0]        in_vld;
    logic [3:0]        in_last;
    logic [DATA_W-1:0] sel_dat;
    logic              sel_vld;
    logic              sel_last;
    logic              in_rdy;
    logic              beat_acc;
    logic [1:0]        arb_grant;
    logic              arb_found;

    assign in_dat[0] = i_s_axis_port0_tdata;
    assign in_dat[1] = i_s_axis_port1_tdata;
    assign in_dat[2] = i_s_axis_port2_tdata;
    assign in_dat[3] = i_s_axis_port3_tdata;
    assign in_vld    = {i_s_axis_port3_tvalid, i_s_axis_port2_tvalid,
                        i_s_axis_port1_tvalid, i_s_axis_port0_tvalid};
    assign in_last   = {i_s_axis_port3_tlast, i_s_axis_port2_tlast,
                        i_s_axis_port1_tlast, i_s_axis_port0_tlast};

    rr_priority_select u_rr_sel (
        .i_req   (in_vld),
        .i_last  (rr_last_q),
        .o_grant (arb_grant),
        .o_found (arb_found)
    );

    // Only the locked port is visible; the slice accepts when empty or draining this cycle.
    always_comb begin
        sel_dat  = in_dat[grant_q];
        sel_vld  = in_vld[grant_q];
        sel_last = in_last[grant_q];
        in_rdy   = (state_q == ST_LOCK) && (!m_vld_q || i_m_axis_tready);
        beat_acc = in_rdy && sel_vld;
    end

    assign o_s_axis_port0_tready = in_rdy && (grant_q == PORT_PLAYER);
    assign o_s_axis_port1_tready = in_rdy && (grant_q == PORT_BULLET);
    assign o_s_axis_port2_tready = in_rdy && (grant_q == PORT_RSVD);
    assign o_s_axis_port3_tready = in_rdy && (grant_q == PORT_ENEMY);

    // Arbitrate only from IDLE; release the lock and advance rotation on the tlast beat.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d = ST_LOCK;
                    grant_d = arb_grant;
                end
            end
            ST_LOCK: begin
                if (beat_acc && sel_last) begin
                    state_d   = ST_IDLE;
                    rr_last_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slice: load on accept, drop valid once drained, otherwise hold.
    always_comb begin
        m_dat_d  = m_dat_q;
        m_vld_d  = m_vld_q;
        m_last_d = m_last_q;
        if (beat_acc) begin
            m_dat_d = sel_dat;
            if (STAMP_TYPE != 0) begin
                m_dat_d[7:0] = pkt_type(grant_q);
            end
            m_vld_d  = 1'b1;
            m_last_d = sel_last;
        end else if (i_m_axis_tready) begin
            m_vld_d  = 1'b0;
            m_last_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight output beat and restarts rotation at port 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= PORT_PLAYER;
            rr_last_q <= PORT_ENEMY;
            m_dat_q   <= '0;
            m_vld_q   <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            m_dat_q   <= m_dat_d;
            m_vld_q   <= m_vld_d;
            m_last_q  <= m_last_d;
        end
    end

    assign o_m_axis_tdata  = m_dat_q;
    assign o_m_axis_tvalid = m_vld_q;
    assign o_m_axis_tlast  = m_last_q;
    assign o_grant         = grant_q;
    assign o_busy          = (state_q == ST_LOCK);

endmodule
